orb_kp_collector: RTL and testbench

- Sink for the two FAST keypoint write streams (XYO_fast1/XYO_fast2 with their write strobes) produced by the ORB extractor.
- Captures one frame's keypoints per channel into two internal buffers.
- On frame end, drains both buffers over a single valid/ready stream (channel 1 first, then channel 2), tagged with channel and last flags.
- Sits between the extractor and the downstream descriptor or matching stage.

---
 rtl/orb_kp_collector.sv | 189 ++++++++++++++++++
 tb/tb_orb_kp_collector.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_kp_collector.sv
// orb_kp_collector: buffers one frame of FAST keypoints per channel, then
// drains channel 1 then channel 2 over one valid/ready stream.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   XYO_fast1/2, wren_XYO_*   : keypoint words and write strobes per channel
//   frame_end                 : one-cycle pulse closing the capture window
//   kp_data/chan/last/valid   : drained beat (chan 0 = ch1), last = final beat
//   kp_ready                  : downstream accept
//   num_fast1/2               : per-channel keypoint count for this frame
//   ovf1/2                    : sticky dropped-write flags
//   busy, frame_done          : draining / drain-complete pulse
module orb_kp_collector #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int XW    = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] XYO_fast1,
    input  logic          wren_XYO_fast1,
    input  logic [XW-1:0] XYO_fast2,
    input  logic          wren_XYO_fast2,
    input  logic          frame_end,
    output logic [XW-1:0] kp_data,
    output logic          kp_chan,
    output logic          kp_last,
    output logic          kp_valid,
    input  logic          kp_ready,
    output logic [13:0]   num_fast1,
    output logic [13:0]   num_fast2,
    output logic          ovf1,
    output logic          ovf2,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        CAPTURE,
        DRAIN1,
        DRAIN2,
        DONE
    } state_e;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);
    localparam logic [AW:0] ZERO = '0;

    state_e        state_q, state_d;
    logic [AW:0]   cnt1_q, cnt1_d;
    logic [AW:0]   cnt2_q, cnt2_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          ovf1_q, ovf1_d;
    logic          ovf2_q, ovf2_d;
    logic          kp_valid_q, kp_valid_d;
    logic          kp_chan_q, kp_chan_d;
    logic          kp_last_q, kp_last_d;
    logic [XW-1:0] kp_data_q;

    logic [XW-1:0] buf1 [DEPTH];
    logic [XW-1:0] buf2 [DEPTH];

    logic          we1, we2;
    logic          draining, rd_sel2, load, xfer;
    logic [AW:0]   cur_cnt;

    always_comb begin
        we1      = (state_q == CAPTURE) && wren_XYO_fast1 && (cnt1_q != FULL);
        we2      = (state_q == CAPTURE) && wren_XYO_fast2 && (cnt2_q != FULL);
        draining = (state_q == DRAIN1) || (state_q == DRAIN2);
        rd_sel2  = (state_q == DRAIN2);
        cur_cnt  = rd_sel2 ? cnt2_q : cnt1_q;
        xfer     = kp_valid_q && kp_ready;
        // Refill the output register whenever it is empty or being consumed.
        load     = draining && (rptr_q < cur_cnt) && (!kp_valid_q || kp_ready);
    end

    always_comb begin
        state_d    = state_q;
        cnt1_d     = cnt1_q + (we1 ? ONE : ZERO);
        cnt2_d     = cnt2_q + (we2 ? ONE : ZERO);
        ovf1_d     = ovf1_q | (wren_XYO_fast1 && !we1);
        ovf2_d     = ovf2_q | (wren_XYO_fast2 && !we2);
        rptr_d     = rptr_q;
        kp_valid_d = kp_valid_q;
        kp_chan_d  = kp_chan_q;
        kp_last_d  = kp_last_q;

        if (load) begin
            kp_valid_d = 1'b1;
            kp_chan_d  = rd_sel2;
            kp_last_d  = (rptr_q == cur_cnt - ONE) && (rd_sel2 || cnt2_q == ZERO);
            rptr_d     = rptr_q + ONE;
        end else if (xfer) begin
            kp_valid_d = 1'b0;
        end

        unique case (state_q)
            CAPTURE: begin
                if (frame_end) begin
                    rptr_d = ZERO;
                    if (cnt1_d != ZERO) begin
                        state_d = DRAIN1;
                    end else if (cnt2_d != ZERO) begin
                        state_d = DRAIN2;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN1: begin
                // Hop to channel 2 as the last ch1 word is fetched: no bubble.
                if (load && rptr_q == cnt1_q - ONE && cnt2_q != ZERO) begin
                    state_d = DRAIN2;
                    rptr_d  = ZERO;
                end else if (xfer && kp_last_q) begin
                    state_d = DONE;
                end
            end
            DRAIN2: begin
                if (xfer && kp_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = CAPTURE;
                cnt1_d  = ZERO;
                cnt2_d  = ZERO;
                ovf1_d  = 1'b0;
                ovf2_d  = 1'b0;
            end
            default: state_d = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CAPTURE;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            rptr_q     <= '0;
            ovf1_q     <= 1'b0;
            ovf2_q     <= 1'b0;
            kp_valid_q <= 1'b0;
            kp_chan_q  <= 1'b0;
            kp_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            rptr_q     <= rptr_d;
            ovf1_q     <= ovf1_d;
            ovf2_q     <= ovf2_d;
            kp_valid_q <= kp_valid_d;
            kp_chan_q  <= kp_chan_d;
            kp_last_q  <= kp_last_d;
        end
    end

    // Buffer write ports; contents are not reset.
    always_ff @(posedge clk) begin
        if (we1) begin
            buf1[cnt1_q[AW-1:0]] <= XYO_fast1;
        end
        if (we2) begin
            buf2[cnt2_q[AW-1:0]] <= XYO_fast2;
        end
    end

    // The output data register doubles as the synchronous RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_data_q <= '0;
        end else if (load) begin
            kp_data_q <= rd_sel2 ? buf2[rptr_q[AW-1:0]] : buf1[rptr_q[AW-1:0]];
        end
    end

    assign kp_data    = kp_data_q;
    assign kp_chan    = kp_chan_q;
    assign kp_last    = kp_last_q;
    assign kp_valid   = kp_valid_q;
    assign num_fast1  = 14'(cnt1_q);
    assign num_fast2  = 14'(cnt2_q);
    assign ovf1       = ovf1_q;
    assign ovf2       = ovf2_q;
    assign busy       = (state_q != CAPTURE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_orb_kp_collector.sv
// Directed bench for orb_kp_collector (DEPTH = 4) with
// hand-computed expected beats.
module tb_orb_kp_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] XYO_fast1, XYO_fast2;
    logic        wren_XYO_fast1, wren_XYO_fast2;
    logic        frame_end;
    logic [21:0] kp_data;
    logic        kp_chan, kp_last, kp_valid, kp_ready;
    logic [13:0] num_fast1, num_fast2;
    logic        ovf1, ovf2, busy, frame_done;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_d [8];
    logic        exp_c [8];
    int          exp_n;
    bit          inj;

    always #5 clk = ~clk;

    orb_kp_collector #(.DEPTH(4), .AW(2), .XW(22)) dut (
        .clk(clk),
        .rst(rst),
        .XYO_fast1(XYO_fast1),
        .wren_XYO_fast1(wren_XYO_fast1),
        .XYO_fast2(XYO_fast2),
        .wren_XYO_fast2(wren_XYO_fast2),
        .frame_end(frame_end),
        .kp_data(kp_data),
        .kp_chan(kp_chan),
        .kp_last(kp_last),
        .kp_valid(kp_valid),
        .kp_ready(kp_ready),
        .num_fast1(num_fast1),
        .num_fast2(num_fast2),
        .ovf1(ovf1),
        .ovf2(ovf2),
        .busy(busy),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit w1, input logic [21:0] d1,
                      input bit w2, input logic [21:0] d2);
        wren_XYO_fast1 = w1;
        XYO_fast1      = d1;
        wren_XYO_fast2 = w2;
        XYO_fast2      = d2;
        tick();
        wren_XYO_fast1 = 1'b0;
        wren_XYO_fast2 = 1'b0;
    endtask

    task automatic fe();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Drains one frame; mode 0: ready high, mode 1: 1010 then 5 low then high.
    task automatic drain(input int mode);
        int          got = 0;
        int          cyc = 0;
        bit          stalled = 0;
        bit          done = 0;
        logic [21:0] sd;
        logic        sc, sl;
        while (!done && cyc < 60) begin
            if (mode == 0) kp_ready = 1'b1;
            else if (cyc < 4) kp_ready = (cyc % 2 == 0);
            else if (cyc < 9) kp_ready = 1'b0;
            else kp_ready = 1'b1;
            if (inj && cyc == 1) begin
                wren_XYO_fast2 = 1'b1;
                XYO_fast2      = 22'h0BAD01;
                frame_end      = 1'b1;
            end else begin
                wren_XYO_fast2 = 1'b0;
                frame_end      = 1'b0;
            end
            if (stalled) check("valid_held", 32'(kp_valid), 32'd1);
            if (kp_valid) begin
                if (stalled) begin
                    check("stall_data", 32'(kp_data), 32'(sd));
                    check("stall_chan", 32'(kp_chan), 32'(sc));
                    check("stall_last", 32'(kp_last), 32'(sl));
                end
                if (kp_ready) begin
                    if (got < exp_n) begin
                        check("beat_data", 32'(kp_data), 32'(exp_d[got]));
                        check("beat_chan", 32'(kp_chan), 32'(exp_c[got]));
                        check("beat_last", 32'(kp_last),
                              32'(got == exp_n - 1));
                    end else begin
                        check("extra_beat", 32'(got), 32'(exp_n - 1));
                    end
                    if (kp_last) done = 1;
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    sd = kp_data;
                    sc = kp_chan;
                    sl = kp_last;
                end
            end
            tick();
            cyc++;
        end
        wren_XYO_fast2 = 1'b0;
        frame_end = 1'b0;
        kp_ready = 1'b0;
        check("beat_count", 32'(got), 32'(exp_n));
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("valid_after_last", 32'(kp_valid), 32'd0);
        if (inj) check("ovf2_in_drain", 32'(ovf2), 32'd1);
        if (inj) check("num2_in_drain", 32'(num_fast2), 32'd0);
        tick();
        check("frame_done_end", 32'(frame_done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("num1_clear", 32'(num_fast1), 32'd0);
        check("num2_clear", 32'(num_fast2), 32'd0);
        check("ovf1_clear", 32'(ovf1), 32'd0);
        check("ovf2_clear", 32'(ovf2), 32'd0);
    endtask

    task automatic load_basic();
        wr(1, 22'h000001, 1, 22'h3FFFFE);
        wr(1, 22'h000002, 1, 22'h3FFFFF);
        wr(1, 22'h000003, 0, 22'h0);
        exp_n = 5;
        exp_d[0] = 22'h000001; exp_c[0] = 0;
        exp_d[1] = 22'h000002; exp_c[1] = 0;
        exp_d[2] = 22'h000003; exp_c[2] = 0;
        exp_d[3] = 22'h3FFFFE; exp_c[3] = 1;
        exp_d[4] = 22'h3FFFFF; exp_c[4] = 1;
    endtask

    initial begin
        int fd_cnt;
        int v_cnt;
        rst = 1'b1;
        XYO_fast1 = '0;
        XYO_fast2 = '0;
        wren_XYO_fast1 = 1'b0;
        wren_XYO_fast2 = 1'b0;
        frame_end = 1'b0;
        kp_ready = 1'b0;
        inj = 0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", 32'(kp_valid), 32'd0);
        check("rst_data", 32'(kp_data), 32'd0);
        check("rst_last", 32'(kp_last), 32'd0);
        check("rst_chan", 32'(kp_chan), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_num1", 32'(num_fast1), 32'd0);
        check("rst_num2", 32'(num_fast2), 32'd0);
        check("rst_ovf", 32'({ovf1, ovf2}), 32'd0);

        // Basic frame with latency check.
        load_basic();
        check("basic_num1", 32'(num_fast1), 32'd3);
        check("basic_num2", 32'(num_fast2), 32'd2);
        check("basic_busy_cap", 32'(busy), 32'd0);
        fe();
        check("lat_n1_valid", 32'(kp_valid), 32'd0);
        check("lat_n1_busy", 32'(busy), 32'd1);
        tick();
        check("lat_n2_valid", 32'(kp_valid), 32'd1);
        check("drain_num1", 32'(num_fast1), 32'd3);
        drain(0);

        // Backpressure.
        load_basic();
        fe();
        tick();
        drain(1);

        // Channel 1 empty.
        wr(0, 22'h0, 1, 22'h0000AA);
        wr(0, 22'h0, 1, 22'h0000BB);
        exp_n = 2;
        exp_d[0] = 22'h0000AA; exp_c[0] = 1;
        exp_d[1] = 22'h0000BB; exp_c[1] = 1;
        fe();
        tick();
        drain(0);

        // Both channels empty.
        fe();
        check("empty_done", 32'(frame_done), 32'd1);
        check("empty_valid", 32'(kp_valid), 32'd0);
        tick();
        check("empty_done_end", 32'(frame_done), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);

        // Overflow on channel 1.
        for (int i = 0; i < 6; i++) wr(1, 22'(32'h10 + i), 0, 22'h0);
        check("ovf_num1", 32'(num_fast1), 32'd4);
        check("ovf_ovf1", 32'(ovf1), 32'd1);
        check("ovf_ovf2", 32'(ovf2), 32'd0);
        exp_n = 4;
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = 22'(32'h10 + i);
            exp_c[i] = 0;
        end
        fe();
        tick();
        drain(0);

        // Write with frame_end; write and frame_end during drain.
        wr(1, 22'h000021, 0, 22'h0);
        wr(1, 22'h000022, 0, 22'h0);
        wren_XYO_fast1 = 1'b1;
        XYO_fast1 = 22'h000023;
        fe();
        wren_XYO_fast1 = 1'b0;
        check("sim_num1", 32'(num_fast1), 32'd3);
        exp_n = 3;
        exp_d[0] = 22'h000021; exp_c[0] = 0;
        exp_d[1] = 22'h000022; exp_c[1] = 0;
        exp_d[2] = 22'h000023; exp_c[2] = 0;
        tick();
        inj = 1;
        drain(0);
        inj = 0;

        // Reset mid-drain.
        load_basic();
        fe();
        tick();
        kp_ready = 1'b1;
        tick();
        tick();
        kp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(kp_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_num1", 32'(num_fast1), 32'd0);
        check("mrst_num2", 32'(num_fast2), 32'd0);
        check("mrst_done", 32'(frame_done), 32'd0);
        fd_cnt = 0;
        v_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            kp_ready = 1'b1;
            if (frame_done) fd_cnt++;
            if (kp_valid) v_cnt++;
            tick();
        end
        kp_ready = 1'b0;
        check("mrst_no_done", 32'(fd_cnt), 32'd0);
        check("mrst_no_beats", 32'(v_cnt), 32'd0);
        wr(1, 22'h000031, 1, 22'h000041);
        exp_n = 2;
        exp_d[0] = 22'h000031; exp_c[0] = 0;
        exp_d[1] = 22'h000041; exp_c[1] = 1;
        fe();
        tick();
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
